// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - one master's request/response port into bus_arbiter
//
// Purpose: bundles everything a single master exchanges with the arbiter.
// Ports (signals):
//   req     master -> arb  master requests a bus cycle
//   lock    master -> arb  master asks to keep ownership next cycle
//   addr    master -> arb  ADDR_W address
//   byteen  master -> arb  write byte enables (0 = read)
//   wdata   master -> arb  DATA_W write data
//   gnt     arb -> master  master owns the bus this cycle
//   ack     arb -> master  transfer completes this cycle
//   rdata   arb -> master  read data (0 when not granted)
// Modports: master (the requester side), slave (the arbiter side).

interface bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              lock;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        byteen;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, lock, addr, byteen, wdata,
    input  gnt, ack, rdata
  );

  modport slave (
    input  req, lock, addr, byteen, wdata,
    output gnt, ack, rdata
  );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master bus arbiter with round robin and bounded lock
//
// Purpose: shares the single Bridge bus between M0 (CPU data port) and M1
// (DMA/debug). Ownership is registered; the bus is muxed combinationally from
// the current owner. Contention is resolved round robin, and a locking owner
// may hold the bus for at most MAX_HOLD consecutive cycles while the other
// master waits.
// Optional feature: define ARB_FIXED_PRIO_EN for fixed priority (M0 always
// wins contention, M1 lock ignored). Default build: round robin + bounded lock.
// Ports:
//   clk         in   1       rising-edge clock
//   reset       in   1       asynchronous, active-high
//   m0, m1      slave modports of bus_arbiter_if (req/lock/addr/byteen/wdata
//                            in; gnt/ack/rdata out)
//   bus_addr    out  ADDR_W  to Bridge
//   bus_byteen  out  4       to Bridge, gated by the owner's req
//   bus_wdata   out  DATA_W  to DM/TC
//   bus_rdata   in   DATA_W  from Bridge
//   owner       out  2       00 none, 01 M0, 10 M1

module bus_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  bus_arbiter_if.slave      m0,
  bus_arbiter_if.slave      m1,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_byteen,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [1:0]        owner
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LIM  = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_M0   = 2'b01,
    OWN_M1   = 2'b10
  } own_t;

  own_t              own_q, own_d;
  logic              last_q, last_d;   // 0 = M0 last owned, 1 = M1
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic cur_lock;
  logic keep;
  own_t rr_pick;
  logic g0, g1;

  // State register. last resets to M1 so M0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      own_q  <= OWN_NONE;
      last_q <= 1'b1;
      hold_q <= '0;
    end else begin
      own_q  <= own_d;
      last_q <= last_d;
      hold_q <= hold_d;
    end
  end

  // Next-owner selection. Depends only on requests, locks and state, never
  // on bus_rdata.
  always_comb begin
    own_d    = OWN_NONE;
    cur_lock = 1'b0;
    case (own_q)
      OWN_M0:  cur_lock = m0.lock;
      OWN_M1:  cur_lock = m1.lock;
      default: cur_lock = 1'b0;
    endcase
    // hold_q counts cycles already kept, so the owner's first cycle is 0 and
    // the last permitted keep happens at MAX_HOLD-2.
    keep    = cur_lock && (hold_q < HOLD_LIM);
    rr_pick = last_q ? OWN_M0 : OWN_M1;

    case ({m1.req, m0.req})
      2'b00: own_d = OWN_NONE;
      2'b01: own_d = OWN_M0;
      2'b10: own_d = OWN_M1;
      default: begin
`ifdef ARB_FIXED_PRIO_EN
        own_d = OWN_M0;
`else
        own_d = keep ? own_q : rr_pick;
`endif
      end
    endcase

    last_d = last_q;
    if (own_d == OWN_M0)
      last_d = 1'b0;
    else if (own_d == OWN_M1)
      last_d = 1'b1;

    if (own_d == OWN_NONE || own_d != own_q)
      hold_d = '0;
    else if (hold_q != HOLD_SAT)
      hold_d = hold_q + 1'b1;
    else
      hold_d = hold_q;
  end

  // Outputs: grant/ack per master and the owner-steered bus mux. A granted
  // master that drops req gets neither an ack nor a write strobe.
  always_comb begin
    g0         = (own_q == OWN_M0);
    g1         = (own_q == OWN_M1);
    m0.gnt     = g0;
    m1.gnt     = g1;
    m0.ack     = g0 & m0.req;
    m1.ack     = g1 & m1.req;
    m0.rdata   = g0 ? bus_rdata : '0;
    m1.rdata   = g1 ? bus_rdata : '0;
    owner      = own_q;
    bus_addr   = '0;
    bus_byteen = 4'h0;
    bus_wdata  = '0;
    case (own_q)
      OWN_M0: begin
        bus_addr   = m0.addr;
        bus_byteen = m0.req ? m0.byteen : 4'h0;
        bus_wdata  = m0.wdata;
      end
      OWN_M1: begin
        bus_addr   = m1.addr;
        bus_byteen = m1.req ? m1.byteen : 4'h0;
        bus_wdata  = m1.wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for bus_arbiter

module tb_bus_arbiter;

  localparam logic [1:0] O_NONE = 2'b00;
  localparam logic [1:0] O_M0   = 2'b01;
  localparam logic [1:0] O_M1   = 2'b10;

  typedef struct {
    logic [1:0]  who;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic [1:0]  owner;

  logic [31:0] dm [0:255] = '{default: 32'h0};
  bit          preload = 1'b1;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
  bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();

  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .m0         (m0_if),
    .m1         (m1_if),
    .bus_addr   (bus_addr),
    .bus_byteen (bus_byteen),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .owner      (owner)
  );

  always #5 clk = ~clk;

  // Bridge model: TC0 word at 0x7f04 reads 0xdead, everything else is DM.
  always_comb bus_rdata = (bus_addr == 32'h7f04) ? 32'hdead : dm[bus_addr[9:2]];

  always @(posedge clk) begin
    if (preload) begin
      dm[64]  <= 32'h11110000;
      dm[128] <= 32'h22220000;
      preload <= 1'b0;
    end else if (bus_byteen != 4'h0 && bus_addr[15:8] != 8'h7f) begin
      for (int b = 0; b < 4; b++)
        if (bus_byteen[b]) dm[bus_addr[9:2]][8*b +: 8] <= bus_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [1:0] who, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wd, input logic [31:0] rd);
    exp_t e;
    e.who = who; e.addr = addr; e.be = be; e.wd = wd; e.rd = rd;
    exp_q.push_back(e);
  endtask

  // Read transaction used by the contention tests; addresses hit preloaded DM words.
  task automatic exp_rd(input logic [1:0] who);
    if (who == O_M0) push(O_M0, 32'h100, 4'h0, 32'h0a0a0a0a, 32'h11110000);
    else             push(O_M1, 32'h200, 4'h0, 32'h0b0b0b0b, 32'h22220000);
  endtask

  task automatic set_m0(input logic req, input logic lock, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
    m0_if.req = req; m0_if.lock = lock; m0_if.addr = addr; m0_if.byteen = be; m0_if.wdata = wd;
  endtask

  task automatic set_m1(input logic req, input logic lock, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
    m1_if.req = req; m1_if.lock = lock; m1_if.addr = addr; m1_if.byteen = be; m1_if.wdata = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every ack pops one expected transfer.
  always @(negedge clk) begin
    if (!reset && (m0_if.ack || m1_if.ack)) begin
      chk("single_ack", {31'b0, m0_if.ack & m1_if.ack}, 32'h0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack owner=%0d required=no ack t=%0t", owner, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ack_owner",  {30'b0, owner}, {30'b0, mon_e.who});
        chk("ack_addr",   bus_addr, mon_e.addr);
        chk("ack_byteen", {28'b0, bus_byteen}, {28'b0, mon_e.be});
        chk("ack_wdata",  bus_wdata, mon_e.wd);
        if (mon_e.who == O_M0) begin
          chk("ack_m0_rdata", m0_if.rdata, mon_e.rd);
          chk("ack_m1_rdata_zero", m1_if.rdata, 32'h0);
        end else begin
          chk("ack_m1_rdata", m1_if.rdata, mon_e.rd);
          chk("ack_m0_rdata_zero", m0_if.rdata, 32'h0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    set_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_m1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_owner",  {30'b0, owner}, {30'b0, O_NONE});
    chk("rst_m0_gnt", {31'b0, m0_if.gnt}, 32'h0);
    chk("rst_m1_gnt", {31'b0, m1_if.gnt}, 32'h0);
    chk("rst_m0_ack", {31'b0, m0_if.ack}, 32'h0);
    chk("rst_byteen", {28'b0, bus_byteen}, 32'h0);
    chk("rst_addr",   bus_addr, 32'h0);

    // Single M0 write: ack one cycle after the request is sampled.
    step();
    reset = 1'b0;
    set_m0(1'b1, 1'b0, 32'h10, 4'hf, 32'h1234);
    push(O_M0, 32'h10, 4'hf, 32'h1234, 32'h0);
    step();
    step();
    m0_if.req = 1'b0;
    chk("dm_write", dm[4], 32'h1234);
    @(negedge clk);
    chk("drop_gnt",    {31'b0, m0_if.gnt}, 32'h1);
    chk("drop_ack",    {31'b0, m0_if.ack}, 32'h0);
    chk("drop_byteen", {28'b0, bus_byteen}, 32'h0);
    step();
    @(negedge clk);
    chk("idle_owner", {30'b0, owner}, {30'b0, O_NONE});

    // M1 reads TC0, then releases.
    step();
    set_m1(1'b1, 1'b0, 32'h7f04, 4'h0, 32'h0);
    push(O_M1, 32'h7f04, 4'h0, 32'h0, 32'hdead);
    step();
    step();
    m1_if.req = 1'b0;
    step();
    @(negedge clk);
    chk("rd_release_owner", {30'b0, owner}, {30'b0, O_NONE});

    // Reset asserted during an M0 write cycle.
    step();
    set_m0(1'b1, 1'b0, 32'h20, 4'hf, 32'hbeef);
    step();
    chk("pre_rst_byteen", {28'b0, bus_byteen}, 32'hf);
    reset = 1'b1;
    #1;
    chk("mid_rst_owner",  {30'b0, owner}, {30'b0, O_NONE});
    chk("mid_rst_byteen", {28'b0, bus_byteen}, 32'h0);
    chk("mid_rst_m0_gnt", {31'b0, m0_if.gnt}, 32'h0);
    set_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (2) step();
    chk("rst_dropped_write", dm[8], 32'h0);

    // Both request without lock, straight out of reset.
    reset = 1'b0;
    set_m0(1'b1, 1'b0, 32'h100, 4'h0, 32'h0a0a0a0a);
    set_m1(1'b1, 1'b0, 32'h200, 4'h0, 32'h0b0b0b0b);
`ifdef ARB_FIXED_PRIO_EN
    repeat (6) exp_rd(O_M0);
`else
    repeat (3) begin
      exp_rd(O_M0);
      exp_rd(O_M1);
    end
`endif
    repeat (7) step();
    m0_if.req = 1'b0;
    m1_if.req = 1'b0;
    step();
    @(negedge clk);
    chk("rr_idle_owner", {30'b0, owner}, {30'b0, O_NONE});

    // M1 takes the bus with lock, then M0 joins; later M0 leaves first.
    step();
    set_m1(1'b1, 1'b1, 32'h200, 4'h0, 32'h0b0b0b0b);
`ifdef ARB_FIXED_PRIO_EN
    exp_rd(O_M1);
    repeat (9) exp_rd(O_M0);
    exp_rd(O_M1);
`else
    repeat (4) exp_rd(O_M1);
    exp_rd(O_M0);
    repeat (4) exp_rd(O_M1);
    exp_rd(O_M0);
    repeat (2) exp_rd(O_M1);
`endif
    step();
    m0_if.req = 1'b1;
    repeat (10) step();
    m0_if.req = 1'b0;
    repeat (2) step();
    m1_if.req  = 1'b0;
    m1_if.lock = 1'b0;
    step();
    @(negedge clk);
    chk("lock_idle_owner", {30'b0, owner}, {30'b0, O_NONE});

    repeat (2) step();
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
